// File: rtl/clock_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : clock_period_meter
// Description : Measures one full period and the high time of a slow signal
//               (typically a clock divider output) sampled in the clk domain.
//               The signal is treated as plain data and synchronised first.
//               Each start request produces a single measurement. The
//               measurement aborts with a sticky timeout flag if sig_in stalls.
// Ports       : clk      - system clock, rising edge
//               rst      - synchronous, active-high reset
//               sig_in   - signal under test (asynchronous to clk)
//               start    - measurement request, sampled only while idle
//               period   - last measured period, in clk cycles
//               high_cnt - last measured high time, in clk cycles
//               valid    - one-cycle pulse when period/high_cnt update
//               busy     - high whenever a measurement is in progress
//               timeout  - sticky: last measurement aborted
// Revision    : 1.0 - initial release
// ============================================================================
module clock_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             valid,
    output logic             busy,
    output logic             timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    // Watchdog compare value: abort on the cycle the counter reaches this.
    localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hi;
    logic [CNT_W-1:0]       r_wcnt;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       r_high;
    logic                   r_valid;
    logic                   r_timeout;

    logic                   w_s;
    logic                   w_rise;
    logic                   w_done;
    logic                   w_abort;
    logic                   w_accept;

    // Sync chain and delay register reset to ones: a sig_in already high at
    // reset release must not look like a rising edge.
    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_s_d;

    // Next-state and control decode
    always_comb begin
        w_next   = r_state;
        w_done   = 1'b0;
        w_abort  = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_ARM;
                end
            end
            ST_ARM: begin
                // A rise here only opens the window; it cannot rescue a timeout.
                if (r_wcnt == c_TO_LAST) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end else if (w_rise) begin
                    w_next = ST_MEAS;
                end
            end
            ST_MEAS: begin
                // The completing rise wins over a simultaneous timeout.
                if (w_rise) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end else if (r_wcnt == c_TO_LAST) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sync    <= '1;
            r_s_d     <= 1'b1;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_wcnt    <= '0;
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sync  <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_s_d   <= w_s;
            r_valid <= w_done;

            if (w_accept) begin
                r_cnt     <= '0;
                r_hi      <= '0;
                r_wcnt    <= '0;
                r_timeout <= 1'b0;
            end

            if (r_state == ST_ARM || r_state == ST_MEAS) begin
                r_wcnt <= r_wcnt + 1'b1;
            end

            // The rise cycle itself counts as the first (high) cycle.
            if (r_state == ST_ARM && w_rise) begin
                r_cnt <= CNT_W'(1);
                r_hi  <= CNT_W'(1);
            end

            if (r_state == ST_MEAS) begin
                if (w_done) begin
                    r_period <= r_cnt;
                    r_high   <= r_hi;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                    r_hi  <= r_hi + {{(CNT_W-1){1'b0}}, w_s};
                end
            end

            if (w_abort) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign period   = r_period;
    assign high_cnt = r_high;
    assign valid    = r_valid;
    assign busy     = (r_state != ST_IDLE);
    assign timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_clock_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_period_meter
// Description : Directed testbench for clock_period_meter (TIMEOUT_CYC=64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_period_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig_in;
    logic        start;
    logic [15:0] period;
    logic [15:0] high_cnt;
    logic        valid;
    logic        busy;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    // Pattern generator: sole driver of sig_in. Updates shortly after each
    // falling edge, so settings made on a falling edge apply immediately.
    logic gen_en    = 1'b0;
    logic gen_level = 1'b0;
    int   gen_hi    = 4;
    int   gen_lo    = 4;
    int   gen_ph    = 0;

    clock_period_meter #(
        .CNT_W       (16),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .start    (start),
        .period   (period),
        .high_cnt (high_cnt),
        .valid    (valid),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (gen_en) begin
                sig_in = (gen_ph < gen_hi);
                gen_ph = (gen_ph + 1) % (gen_hi + gen_lo);
            end else begin
                sig_in = gen_level;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got=hang want=finish");
        $fatal(1, "watchdog");
    end

    task automatic set_pattern(input int hi, input int lo);
        gen_hi = hi;
        gen_lo = lo;
        gen_en = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic set_level(input logic lvl, input int n);
        gen_en    = 1'b0;
        gen_level = lvl;
        repeat (n) @(negedge clk);
    endtask

    // Ends on the falling edge following the accepting rising edge.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (valid) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        set_level(1'b0, 4);
        rst = 1'b0;
        @(negedge clk);
        total++; if (period !== 16'd0) begin bad++; $display("FAIL reset_period got=%0d want=0", period); end
        total++; if (high_cnt !== 16'd0) begin bad++; $display("FAIL reset_high got=%0d want=0", high_cnt); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
    endtask

    task automatic test_basic();
        bit got;
        set_pattern(4, 4);
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
        wait_valid(60, got);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", got); end
        total++; if (period !== 16'd8) begin bad++; $display("FAIL basic_period got=%0d want=8", period); end
        total++; if (high_cnt !== 16'd4) begin bad++; $display("FAIL basic_high got=%0d want=4", high_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_in_valid got=%b want=0", busy); end
        @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL basic_valid_one_cycle got=%b want=0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        bit got;
        set_pattern(3, 7);
        pulse_start();
        wait_valid(60, got);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL b2b_first_valid got=%b want=1", got); end
        total++; if (period !== 16'd10) begin bad++; $display("FAIL b2b_first_period got=%0d want=10", period); end
        total++; if (high_cnt !== 16'd3) begin bad++; $display("FAIL b2b_first_high got=%0d want=3", high_cnt); end
        // Start raised during the valid cycle must be accepted.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy got=%b want=1", busy); end
        wait_valid(60, got);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL b2b_second_valid got=%b want=1", got); end
        total++; if (period !== 16'd10) begin bad++; $display("FAIL b2b_second_period got=%0d want=10", period); end
        total++; if (high_cnt !== 16'd3) begin bad++; $display("FAIL b2b_second_high got=%0d want=3", high_cnt); end
    endtask

    task automatic test_timeout();
        bit got;
        int k;
        bit saw_valid;
        set_level(1'b0, 5);
        pulse_start();
        k = 0;
        saw_valid = 1'b0;
        while (k < 80) begin
            @(negedge clk);
            k++;
            if (valid) saw_valid = 1'b1;
            if (timeout) break;
        end
        total++; if (k !== 64) begin bad++; $display("FAIL to_latency got=%0d want=64", k); end
        total++; if (saw_valid !== 1'b0) begin bad++; $display("FAIL to_no_valid got=%b want=0", saw_valid); end
        total++; if (period !== 16'd10) begin bad++; $display("FAIL to_period_kept got=%0d want=10", period); end
        total++; if (high_cnt !== 16'd3) begin bad++; $display("FAIL to_high_kept got=%0d want=3", high_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_busy got=%b want=0", busy); end
        set_pattern(4, 4);
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", timeout); end
        pulse_start();
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_clear got=%b want=0", timeout); end
        wait_valid(60, got);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL to_next_valid got=%b want=1", got); end
        total++; if (period !== 16'd8) begin bad++; $display("FAIL to_next_period got=%0d want=8", period); end
    endtask

    task automatic test_start_while_busy();
        int nval;
        nval = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            if (valid) nval++;
            start = busy;
            @(negedge clk);
        end
        start = 1'b0;
        total++; if (nval !== 1) begin bad++; $display("FAIL busy_valid_count got=%0d want=1", nval); end
        total++; if (period !== 16'd8) begin bad++; $display("FAIL busy_period got=%0d want=8", period); end
        total++; if (high_cnt !== 16'd4) begin bad++; $display("FAIL busy_high got=%0d want=4", high_cnt); end
    endtask

    task automatic test_reset_mid_meas();
        bit got;
        int nval;
        set_level(1'b0, 5);
        pulse_start();
        set_level(1'b0, 3);
        set_level(1'b1, 8);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy got=%b want=1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (period !== 16'd0) begin bad++; $display("FAIL rst_mid_period got=%0d want=0", period); end
        total++; if (high_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid_high got=%0d want=0", high_cnt); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_mid_timeout got=%b want=0", timeout); end
        pulse_start();
        nval = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid) nval++;
        end
        total++; if (nval !== 0) begin bad++; $display("FAIL rst_false_rise got=%0d want=0", nval); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_armed_busy got=%b want=1", busy); end
        set_level(1'b0, 5);
        set_level(1'b1, 4);
        set_level(1'b0, 6);
        gen_level = 1'b1;
        wait_valid(20, got);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL rst_after_valid got=%b want=1", got); end
        total++; if (period !== 16'd10) begin bad++; $display("FAIL rst_after_period got=%0d want=10", period); end
        total++; if (high_cnt !== 16'd4) begin bad++; $display("FAIL rst_after_high got=%0d want=4", high_cnt); end
    endtask

    task automatic test_min_period();
        bit got;
        set_pattern(1, 1);
        pulse_start();
        wait_valid(40, got);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL min_valid got=%b want=1", got); end
        total++; if (period !== 16'd2) begin bad++; $display("FAIL min_period got=%0d want=2", period); end
        total++; if (high_cnt !== 16'd1) begin bad++; $display("FAIL min_high got=%0d want=1", high_cnt); end
    endtask

    // Completing rise lands exactly on the last watchdog cycle.
    task automatic test_rise_on_timeout();
        set_level(1'b0, 5);
        pulse_start();
        gen_level = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k == 10) gen_level = 1'b0;
            if (k == 61) gen_level = 1'b1;
            if (k == 63) begin
                total++; if (valid !== 1'b0) begin bad++; $display("FAIL edge_early_valid got=%b want=0", valid); end
            end
        end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL edge_valid got=%b want=1", valid); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL edge_timeout got=%b want=0", timeout); end
        total++; if (period !== 16'd61) begin bad++; $display("FAIL edge_period got=%0d want=61", period); end
        total++; if (high_cnt !== 16'd10) begin bad++; $display("FAIL edge_high got=%0d want=10", high_cnt); end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_start_while_busy();
        test_reset_mid_meas();
        test_min_period();
        test_rise_on_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
